// File: rtl/program_loader.sv
// Streams 16-bit instruction words into a byte-wide program memory, low byte first,
// until the halt sentinel is stored or the top of the address space is reached.
module program_loader #(
  parameter logic [7:0]  BASE_ADDR = 8'h00,
  parameter logic [15:0] HALT_WORD = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_clear,
  input  logic        in_valid,
  input  logic [15:0] in_word,
  output logic        in_ready,
  output logic [7:0]  Address,
  output logic [7:0]  Data,
  output logic        Mem_WR,
  output logic        Mem_CS,
  output logic [7:0]  word_count,
  output logic        done,
  output logic        full
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR_LO = 3'd1,
    WR_HI = 3'd2,
    DONE  = 3'd3,
    FULL  = 3'd4
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [7:0]  addr_r;
  logic [7:0]  addr_nxt_s;
  logic [7:0]  count_nxt_s;
  logic [15:0] buf_r;
  logic [15:0] buf_nxt_s;

  function automatic logic is_write(input state_t s);
    case (s)
      WR_LO:   is_write = 1'b1;
      WR_HI:   is_write = 1'b1;
      default: is_write = 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] byte_for(input state_t s, input logic [15:0] w);
    case (s)
      WR_LO:   byte_for = w[7:0];
      WR_HI:   byte_for = w[15:8];
      default: byte_for = 8'h00;
    endcase
  endfunction

  assign in_ready = (state_r == IDLE) && !in_clear;
  assign Address  = addr_r;

  // Next-state, pointer, counter and buffer computation
  always_comb begin
    state_nxt_s = state_r;
    addr_nxt_s  = addr_r;
    count_nxt_s = word_count;
    buf_nxt_s   = buf_r;
    case (state_r)
      IDLE: begin
        if (in_valid && !in_clear) begin
          buf_nxt_s   = in_word;
          state_nxt_s = WR_LO;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WR_LO: begin
        addr_nxt_s  = addr_r + 8'd1;
        state_nxt_s = WR_HI;
      end
      WR_HI: begin
        addr_nxt_s  = addr_r + 8'd1;
        count_nxt_s = word_count + 8'd1;
        // The sentinel wins even when it lands in the last two bytes.
        if (buf_r == HALT_WORD) begin
          state_nxt_s = DONE;
        end else if (addr_r == 8'hFF) begin
          state_nxt_s = FULL;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      DONE:    state_nxt_s = DONE;
      FULL:    state_nxt_s = FULL;
      default: state_nxt_s = IDLE;
    endcase
    if (in_clear) begin
      state_nxt_s = IDLE;
      addr_nxt_s  = BASE_ADDR;
      count_nxt_s = 8'd0;
    end else begin
      buf_nxt_s = buf_nxt_s;
    end
  end

  // State registers plus memory-side outputs decoded from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      addr_r     <= BASE_ADDR;
      word_count <= 8'd0;
      buf_r      <= 16'h0000;
      Mem_CS     <= 1'b1;
      Mem_WR     <= 1'b0;
      Data       <= 8'h00;
      done       <= 1'b0;
      full       <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      addr_r     <= addr_nxt_s;
      word_count <= count_nxt_s;
      buf_r      <= buf_nxt_s;
      Mem_CS     <= !is_write(state_nxt_s);
      Mem_WR     <= is_write(state_nxt_s);
      Data       <= byte_for(state_nxt_s, buf_nxt_s);
      done       <= (state_nxt_s == DONE);
      full       <= (state_nxt_s == FULL);
    end
  end

endmodule
